// File: rtl/cache_pkg.sv
// Shared types for the cache-side memory line engine: word/line typedefs,
// line offset width and the line-master FSM state encoding.
package cache_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE) + 2;

  typedef logic [WORD_WIDTH-1:0] mem_word_t;
  typedef mem_word_t line_t [WORDS_PER_LINE];

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } master_state_e;

endpackage

// File: rtl/mem_line_master.sv
// Line fill / writeback initiator: splits one cache line command into
// WORDS_PER_LINE back-to-back word transactions on the memory interface.
module mem_line_master #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmdValid,
  output logic                                 cmdReady,
  input  logic                                 cmdWrite,
  input  logic [ADDRESS_WIDTH-1:0]             cmdAddress,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] cmdLineData,
  output logic                                 rspValid,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] rspLineData,
  output logic                                 memReqValid,
  output logic [ADDRESS_WIDTH-1:0]             memReqAddress,
  output logic [WORD_WIDTH-1:0]                memReqDataIn,
  output logic                                 memReqWen,
  input  logic                                 memRespValid,
  input  logic [WORD_WIDTH-1:0]                memRespDataOut
);

  import cache_pkg::*;

  localparam int IDX_W    = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS = IDX_W + 2;
  localparam int LINE_W   = WORD_WIDTH * WORDS_PER_LINE;

  master_state_e state, state_next;

  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [LINE_W-1:0]        wline_q;
  logic [LINE_W-1:0]        rbuf_q;
  logic [LINE_W-1:0]        fill_line;
  logic [IDX_W-1:0]         index_q;
  logic                     accept;
  logic                     word_done;
  logic                     last_word;

  assign accept    = (state == IDLE) && cmdValid;
  assign word_done = (state == XFER) && memRespValid;
  assign last_word = (index_q == IDX_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmdValid) state_next = XFER;
      XFER:    if (word_done && last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request lines are zero outside XFER so idle/reset values stay clean.
  always_comb begin
    cmdReady      = (state == IDLE);
    rspValid      = (state == DONE);
    memReqValid   = (state == XFER);
    memReqWen     = (state == XFER) && write_q;
    memReqAddress = '0;
    memReqDataIn  = '0;
    if (state == XFER) begin
      memReqAddress = base_q | (ADDRESS_WIDTH'(index_q) << 2);
      memReqDataIn  = wline_q[index_q*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  // Line buffer with the word arriving this cycle merged in, so the final
  // word can be published in the same edge that completes it.
  always_comb begin
    fill_line = rbuf_q;
    fill_line[index_q*WORD_WIDTH +: WORD_WIDTH] = memRespDataOut;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q     <= 1'b0;
      base_q      <= '0;
      wline_q     <= '0;
      rbuf_q      <= '0;
      index_q     <= '0;
      rspLineData <= '0;
    end else begin
      if (accept) begin
        write_q <= cmdWrite;
        base_q  <= {cmdAddress[ADDRESS_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
        wline_q <= cmdLineData;
        index_q <= '0;
      end
      if (word_done) begin
        index_q <= index_q + 1'b1;
        if (!write_q) begin
          rbuf_q <= fill_line;
          if (last_word) rspLineData <= fill_line;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: a DELAY=4 word memory responder plus a flat
// array reference of memory contents predicting every line and transaction.
module tb_mem_line_master;

  localparam int AW    = 32;
  localparam int WW    = 32;
  localparam int WPL   = 4;
  localparam int LW    = WW * WPL;
  localparam int DELAY = 4;
  localparam int WORD_CYCLES = (DELAY + 1) * WPL;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmdValid;
  logic          cmdReady;
  logic          cmdWrite;
  logic [AW-1:0] cmdAddress;
  logic [LW-1:0] cmdLineData;
  logic          rspValid;
  logic [LW-1:0] rspLineData;
  logic          memReqValid;
  logic [AW-1:0] memReqAddress;
  logic [WW-1:0] memReqDataIn;
  logic          memReqWen;
  logic          memRespValid;
  logic [WW-1:0] memRespDataOut;

  always #5 clk = ~clk;

  mem_line_master #(
    .ADDRESS_WIDTH (AW),
    .WORD_WIDTH    (WW),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmdValid      (cmdValid),
    .cmdReady      (cmdReady),
    .cmdWrite      (cmdWrite),
    .cmdAddress    (cmdAddress),
    .cmdLineData   (cmdLineData),
    .rspValid      (rspValid),
    .rspLineData   (rspLineData),
    .memReqValid   (memReqValid),
    .memReqAddress (memReqAddress),
    .memReqDataIn  (memReqDataIn),
    .memReqWen     (memReqWen),
    .memRespValid  (memRespValid),
    .memRespDataOut(memRespDataOut)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [WW-1:0] mem_arr [1024];
  logic [WW-1:0] ref_mem [1024];
  bit            mem_enable;
  int            mem_cnt;
  logic [AW-1:0] acc_addr [$];
  bit            acc_wen  [$];
  logic [WW-1:0] acc_data [$];
  logic [LW-1:0] last_fill;

  // Word memory: answers each request DELAY+1 cycles after it appears and
  // drops its response on the edge that consumes it.
  initial begin
    memRespValid   = 1'b0;
    memRespDataOut = '0;
    mem_cnt        = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_enable) begin
        if (rst || memRespValid) begin
          memRespValid = 1'b0;
          mem_cnt      = 0;
        end
        if (!rst && memReqValid) begin
          mem_cnt++;
          if (mem_cnt == DELAY + 1) begin
            acc_addr.push_back(memReqAddress);
            acc_wen.push_back(memReqWen);
            acc_data.push_back(memReqDataIn);
            if (memReqWen) mem_arr[memReqAddress[11:2]] = memReqDataIn;
            else           memRespDataOut = mem_arr[memReqAddress[11:2]];
            memRespValid = 1'b1;
          end
        end else begin
          mem_cnt = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] expLine(input logic [AW-1:0] base);
    logic [LW-1:0] l;
    logic [9:0]    w;
    for (int i = 0; i < WPL; i++) begin
      w = base[11:2] + 10'(i);
      l[i*WW +: WW] = ref_mem[w];
    end
    return l;
  endfunction

  task automatic clearAccesses();
    acc_addr.delete();
    acc_wen.delete();
    acc_data.delete();
  endtask

  task automatic checkAccesses(input logic [AW-1:0] base, input bit wr, input logic [LW-1:0] line);
    checkOutput("access_count", LW'(acc_addr.size()), LW'(WPL));
    for (int i = 0; i < WPL && i < acc_addr.size(); i++) begin
      checkOutput($sformatf("req_addr%0d", i), LW'(acc_addr[i]), LW'(base + AW'(4 * i)));
      checkOutput($sformatf("req_wen%0d", i), LW'(acc_wen[i]), LW'(wr));
      if (wr) checkOutput($sformatf("req_wdata%0d", i), LW'(acc_data[i]), LW'(line[i*WW +: WW]));
    end
  endtask

  // Presents a command from a negedge and returns #1 after its accept edge.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] line);
    int guard = 0;
    @(negedge clk);
    while (!cmdReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("cmd_ready_timeout", 0, 1);
    cmdValid    = 1'b1;
    cmdWrite    = wr;
    cmdAddress  = addr;
    cmdLineData = line;
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int gaps);
    cycles = 0;
    gaps   = 0;
    while (cycles < 200) begin
      if (!memReqValid || cmdReady || rspValid) gaps++;
      @(posedge clk);
      #1;
      cycles++;
      if (rspValid) break;
    end
  endtask

  task automatic updateRef(input logic [AW-1:0] base, input logic [LW-1:0] line);
    logic [9:0] w;
    for (int i = 0; i < WPL; i++) begin
      w = base[11:2] + 10'(i);
      ref_mem[w] = line[i*WW +: WW];
    end
  endtask

  task automatic runCommand(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] line);
    logic [AW-1:0] base;
    int            cycles;
    int            gaps;
    base = addr & ~AW'(32'hF);
    clearAccesses();
    applyStimulus(wr, addr, line);
    waitDone(cycles, gaps);
    checkOutput("latency", LW'(cycles), LW'(WORD_CYCLES));
    checkOutput("req_gaps", LW'(gaps), 0);
    checkAccesses(base, wr, line);
    if (wr) updateRef(base, line);
    else    last_fill = expLine(base);
    checkOutput("rsp_line", rspLineData, last_fill);
    @(posedge clk);
    #1;
    checkOutput("rsp_pulse_len", LW'(rspValid), 0);
    checkOutput("ready_after_done", LW'(cmdReady), 1);
  endtask

  initial begin
    int            cycles;
    int            gaps;
    int            guard;
    int            stray;
    logic [AW-1:0] a;
    logic [LW-1:0] l;

    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    end
    mem_enable  = 1'b1;
    last_fill   = '0;
    rst         = 1'b1;
    cmdValid    = 1'b0;
    cmdWrite    = 1'b0;
    cmdAddress  = '0;
    cmdLineData = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cmdReady", LW'(cmdReady), 1);
    checkOutput("reset_rspValid", LW'(rspValid), 0);
    checkOutput("reset_rspLineData", rspLineData, 0);
    checkOutput("reset_memReqValid", LW'(memReqValid), 0);
    checkOutput("reset_memReqAddress", LW'(memReqAddress), 0);
    checkOutput("reset_memReqDataIn", LW'(memReqDataIn), 0);
    checkOutput("reset_memReqWen", LW'(memReqWen), 0);
    rst = 1'b0;

    $display("[TB] writeback then fill at 0x100");
    runCommand(1'b1, 32'h100, {32'd44, 32'd33, 32'd22, 32'd11});
    runCommand(1'b0, 32'h100, '0);
    checkOutput("fill_0x100_literal", rspLineData, {32'd44, 32'd33, 32'd22, 32'd11});

    $display("[TB] unaligned fill at 0x10B");
    runCommand(1'b0, 32'h10B, '0);
    checkOutput("fill_0x10B_literal", rspLineData, {32'd44, 32'd33, 32'd22, 32'd11});

    $display("[TB] back-to-back commands with cmdValid held");
    clearAccesses();
    l = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    applyStimulus(1'b1, 32'h240, l);
    cmdValid    = 1'b1;
    cmdWrite    = 1'b0;
    cmdAddress  = 32'h244;
    cmdLineData = '0;
    waitDone(cycles, gaps);
    checkOutput("b2b_latency1", LW'(cycles), LW'(WORD_CYCLES));
    checkOutput("b2b_gaps1", LW'(gaps), 0);
    checkAccesses(32'h240, 1'b1, l);
    updateRef(32'h240, l);
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_ready", LW'(cmdReady), 1);
    checkOutput("b2b_idle_reqValid", LW'(memReqValid), 0);
    checkOutput("b2b_idle_rspValid", LW'(rspValid), 0);
    clearAccesses();
    @(posedge clk);
    #1;
    cmdValid = 1'b0;
    checkOutput("b2b_accept_reqValid", LW'(memReqValid), 1);
    checkOutput("b2b_accept_ready", LW'(cmdReady), 0);
    checkOutput("b2b_accept_addr", LW'(memReqAddress), LW'(32'h240));
    waitDone(cycles, gaps);
    checkOutput("b2b_latency2", LW'(cycles), LW'(WORD_CYCLES));
    checkOutput("b2b_gaps2", LW'(gaps), 0);
    checkAccesses(32'h240, 1'b0, '0);
    last_fill = expLine(32'h240);
    checkOutput("b2b_fill_line", rspLineData, l);
    @(posedge clk);
    #1;

    $display("[TB] reset during word 2 of a fill");
    clearAccesses();
    applyStimulus(1'b0, 32'h380, '0);
    guard = 0;
    while (acc_addr.size() < 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reset_mid_first_word", LW'(acc_addr.size()), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_cmdReady", LW'(cmdReady), 1);
    checkOutput("midrst_rspValid", LW'(rspValid), 0);
    checkOutput("midrst_rspLineData", rspLineData, 0);
    checkOutput("midrst_memReqValid", LW'(memReqValid), 0);
    checkOutput("midrst_memReqAddress", LW'(memReqAddress), 0);
    checkOutput("midrst_memReqDataIn", LW'(memReqDataIn), 0);
    checkOutput("midrst_memReqWen", LW'(memReqWen), 0);
    @(negedge clk);
    rst       = 1'b0;
    last_fill = '0;
    stray     = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rspValid || memReqValid) stray++;
    end
    checkOutput("midrst_no_stray", LW'(stray), 0);
    runCommand(1'b0, 32'h380, '0);

    $display("[TB] memRespValid forced while idle");
    @(negedge clk);
    mem_enable     = 1'b0;
    memRespValid   = 1'b1;
    memRespDataOut = 32'hDEAD_BEEF;
    stray          = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!cmdReady || memReqValid || rspValid) stray++;
    end
    checkOutput("idle_resp_ignored", LW'(stray), 0);
    checkOutput("idle_resp_line_kept", rspLineData, last_fill);
    @(negedge clk);
    memRespValid = 1'b0;
    mem_enable   = 1'b1;

    $display("[TB] randomized commands");
    for (int n = 0; n < 12; n++) begin
      a = $urandom;
      l = {$urandom, $urandom, $urandom, $urandom};
      runCommand(1'($urandom_range(0, 1)), a, l);
    end
    runCommand(1'b0, a, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
